vga_mode_ctrl: RTL
==================

Name: vga_mode_ctrl

Overview:
- Controller for the VGA display datapath. Turns the KEY[2:0] pushbuttons into display configuration: pattern mode, brightness level and freeze.
- Changes are buffered as pending and committed only at the start of vertical sync. This keeps the pixel generator from switching configuration mid-frame.
- Sits between the board keys and the pixel/color generator inside vga_main. It takes vs from the timing generator.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive identical synced samples needed to accept a key level (20 ms at 50 MHz); counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
- NUM_MODES, 4, number of pattern modes; mode wraps NUM_MODES-1 -> 0; legal range 2..4.
- AUTO_FRAMES, 120, frames between automatic mode advances (used only with the optional feature).

Ports:
- CLOCK_50M  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- KEY  in  3  pushbuttons, active-low, asynchronous; [0] next mode, [1] brightness up, [2] freeze toggle
- vs  in  1  vertical sync from timing generator, active-low, asynchronous to key logic
- mode  out  2  committed pattern mode
- level  out  3  committed brightness, 0..7
- frozen  out  1  1 = commits blocked
- pending  out  1  1 = uncommitted change held
- cfg_update  out  1  one-cycle pulse on the cycle mode/level change

Behaviour:
- Reset (sync, high) values:
  - mode=0, level=7, frozen=0, pending=0, cfg_update=0.
  - Shadow mode=0, shadow level=7.
  - Debounced key states=1 (released), debounce counters=0.
  - Synchronizer flops=1, FSM=IDLE.
  - Reset asserted mid-debounce or mid-pending discards everything; no commit occurs.
- Synchronization: KEY and vs each pass through 2 flops before use.
- Debounce, per key:
  - If the synced sample equals the debounced state, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced state takes the sample and the counter clears.
  - A press event is a one-cycle strobe on a debounced 1->0 transition. Release generates no event.
- Press handling, in the cycle after the strobe:
  - KEY[0]: shadow mode +1, wrapping at NUM_MODES-1 -> 0.
  - KEY[1]: shadow level +1, wrapping 7 -> 0.
  - KEY[0] or KEY[1] event sets pending=1.
  - KEY[2]: toggles frozen immediately and does not touch pending.
  - Simultaneous events on several keys in the same cycle are all applied.
- Frame edge: vs_fall is a one-cycle strobe on a synced vs 1->0 transition.
- FSM:
  - IDLE: on a KEY[0]/KEY[1] event -> PENDING.
  - PENDING: on vs_fall with frozen=0 -> COMMIT. Further events stay in PENDING and keep accumulating in the shadow registers. vs_fall while frozen=1 is ignored.
  - COMMIT (one cycle): mode<=shadow mode, level<=shadow level, cfg_update=1, pending<=0 -> IDLE.
  - A key event arriving in the COMMIT cycle updates the shadow and sets pending, and the FSM goes to PENDING instead of IDLE. That event is therefore never lost.
  - cfg_update is asserted only when the committed values actually change. If a wrap returns shadow to the current values, the commit still clears pending but cfg_update stays 0.
- Latency:
  - Debounced press -> pending=1: 1 cycle.
  - Raw vs falling edge -> mode/level update: 2 synchronizer + 1 edge + 1 COMMIT = 4 cycles.
- Unfreezing with pending=1 commits at the next vs_fall, not immediately.

Optional Feature:
- Macro: VGA_MODE_CTRL_AUTO_CYCLE_EN.
- With the macro defined:
  - A frame counter counts vs_fall events while frozen=0 and pending=0.
  - When it reaches AUTO_FRAMES, shadow mode advances by one (with wrap) and the FSM commits at that same vs_fall, so cfg_update pulses.
  - The counter resets to 0 on reset, on any key event, and after each auto advance.
- Without the macro: the counter is not generated and AUTO_FRAMES is unused. Mode changes only on KEY[0].

Test Plan (DEBOUNCE_CYCLES=4, NUM_MODES=4, AUTO_FRAMES=3):
- Reset held 5 cycles then released, keys idle (all 1) -> mode=0, level=7, frozen=0, pending=0, cfg_update never 1.
- KEY[0] low for 2 cycles (bounce) then high, then KEY[0] low for 10 cycles, then one vs low pulse:
  - The bounce produces no event.
  - The 10-cycle press sets pending=1.
  - 4 cycles after the vs falling edge: mode=1 and a single cfg_update pulse.
- 4 separate KEY[0] presses before one vs pulse -> shadow wraps to 0 and pending=1; at commit mode stays 0, pending clears, cfg_update=0.
- Press KEY[2] (frozen=1), press KEY[1], then 3 vs pulses:
  - level stays 7 and pending=1 throughout.
  - Press KEY[2] again; the next vs pulse gives level=0 (wrap from 7) with a cfg_update pulse.
- KEY[0] and KEY[1] released to pressed on the same cycle, then assert reset before vs -> after reset, mode=0, level=7, pending=0; a later vs pulse causes no update.
- With VGA_MODE_CTRL_AUTO_CYCLE_EN defined, no keys, 3 vs pulses -> mode=1 with one cfg_update pulse; 3 more pulses give mode=2. Without the macro: mode stays 0.

Source files
------------

// File: rtl/vga_mode_ctrl.sv
// Key-driven display configuration (mode, brightness, freeze) committed on vsync falling edge.
// Optional auto mode cycling: define VGA_MODE_CTRL_AUTO_CYCLE_EN.
module vga_mode_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned NUM_MODES       = 4,
   parameter int unsigned AUTO_FRAMES     = 120
) (
   input  logic       CLOCK_50M,
   input  logic       reset,
   input  logic [2:0] KEY,
   input  logic       vs,
   output logic [1:0] mode,
   output logic [2:0] level,
   output logic       frozen,
   output logic       pending,
   output logic       cfg_update
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DB_LIMIT  = CW'(DEBOUNCE_CYCLES);
   localparam logic [1:0]    MODE_LAST = 2'(NUM_MODES - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PENDING = 2'd1;
   localparam logic [1:0] ST_COMMIT  = 2'd2;

   logic [2:0]    key_meta, key_sync;
   logic          vs_meta, vs_sync, vs_prev;
   logic [2:0]    key_db, key_db_next;
   logic [2:0]    press, press_next;
   logic [CW-1:0] db_cnt [3];
   logic [CW-1:0] db_cnt_next [3];

   logic [1:0] state, state_next;
   logic [1:0] shadow_mode, shadow_mode_next;
   logic [2:0] shadow_level, shadow_level_next;
   logic [1:0] mode_next;
   logic [2:0] level_next;
   logic       frozen_next, pending_next, cfg_update_next;
   logic       vs_fall, key_event, auto_fire;

   assign vs_fall   = vs_prev & ~vs_sync;
   assign key_event = press[0] | press[1];

   always_ff @(posedge CLOCK_50M) begin
      if (reset) begin
         key_meta <= '1;
         key_sync <= '1;
         vs_meta  <= 1'b1;
         vs_sync  <= 1'b1;
         vs_prev  <= 1'b1;
      end else begin
         key_meta <= KEY;
         key_sync <= key_meta;
         vs_meta  <= vs;
         vs_sync  <= vs_meta;
         vs_prev  <= vs_sync;
      end
   end

   // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      key_db_next = key_db;
      press_next  = '0;
      for (int i = 0; i < 3; i++) begin
         db_cnt_next[i] = '0;
         if (key_sync[i] != key_db[i]) begin
            if (db_cnt[i] + 1'b1 == DB_LIMIT) begin
               key_db_next[i] = key_sync[i];
               press_next[i]  = ~key_sync[i];
            end else begin
               db_cnt_next[i] = db_cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef VGA_MODE_CTRL_AUTO_CYCLE_EN
   localparam int unsigned FW = $clog2(AUTO_FRAMES + 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_FRAMES - 1);

   logic [FW-1:0] frame_cnt;
   logic          frame_tick;

   assign frame_tick = vs_fall & ~frozen & ~pending & (state == ST_IDLE);
   assign auto_fire  = frame_tick && (frame_cnt == FRAME_LAST) && (press == 3'b000);

   always_ff @(posedge CLOCK_50M) begin
      if (reset || (press != 3'b000) || auto_fire) begin
         frame_cnt <= '0;
      end else if (frame_tick) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end
`else
   // AUTO_FRAMES only matters when auto cycling is built in.
   assign auto_fire = 1'b0 && (AUTO_FRAMES != 0);
`endif

   always_comb begin
      state_next        = state;
      shadow_mode_next  = shadow_mode;
      shadow_level_next = shadow_level;
      mode_next         = mode;
      level_next        = level;
      frozen_next       = frozen;
      pending_next      = pending;
      cfg_update_next   = 1'b0;

      if (press[0]) shadow_mode_next = (shadow_mode == MODE_LAST) ? 2'd0 : shadow_mode + 2'd1;
      if (press[1]) shadow_level_next = shadow_level + 3'd1;
      if (press[2]) frozen_next = ~frozen;

      case (state)
         ST_IDLE: begin
            if (key_event) begin
               state_next = ST_PENDING;
            end else if (auto_fire) begin
               shadow_mode_next = (shadow_mode == MODE_LAST) ? 2'd0 : shadow_mode + 2'd1;
               state_next       = ST_COMMIT;
            end
         end
         ST_PENDING: begin
            if (vs_fall && !frozen) state_next = ST_COMMIT;
         end
         ST_COMMIT: begin
            mode_next       = shadow_mode;
            level_next      = shadow_level;
            cfg_update_next = (shadow_mode != mode) || (shadow_level != level);
            pending_next    = 1'b0;
            state_next      = key_event ? ST_PENDING : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      // An event in the commit cycle re-arms pending so it is not lost.
      if (key_event) pending_next = 1'b1;
   end

   always_ff @(posedge CLOCK_50M) begin
      if (reset) begin
         key_db       <= '1;
         press        <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
         state        <= ST_IDLE;
         shadow_mode  <= 2'd0;
         shadow_level <= 3'd7;
         mode         <= 2'd0;
         level        <= 3'd7;
         frozen       <= 1'b0;
         pending      <= 1'b0;
         cfg_update   <= 1'b0;
      end else begin
         key_db       <= key_db_next;
         press        <= press_next;
         for (int i = 0; i < 3; i++) db_cnt[i] <= db_cnt_next[i];
         state        <= state_next;
         shadow_mode  <= shadow_mode_next;
         shadow_level <= shadow_level_next;
         mode         <= mode_next;
         level        <= level_next;
         frozen       <= frozen_next;
         pending      <= pending_next;
         cfg_update   <= cfg_update_next;
      end
   end

endmodule
